// File: rtl/inference_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inference_ctrl
// Description : Sequences one spiking-network inference. It feeds buffered
//               input vectors on request, counts output spikes and reports
//               the winning output.
// Revision    : 1.0 - initial release
// ============================================================================
module inference_ctrl #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int SAMP_W = 8,
    parameter int CNT_W  = 8,
    localparam int CLS_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_go,
    input  logic              i_abort,
    input  logic [SAMP_W-1:0] i_cfg_n_samples,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [N_IN-1:0]   i_in_data,
    output logic              o_net_start,
    input  logic              i_net_ready,
    input  logic              i_net_sample,
    output logic              o_net_sample_ready,
    output logic [N_IN-1:0]   o_net_in_spikes,
    input  logic [N_OUT-1:0]  i_net_out_spikes,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [CLS_W-1:0]  o_res_class,
    output logic [CNT_W-1:0]  o_res_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_NET = 3'd1,
        S_RUN      = 3'd2,
        S_STALL    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_buf_valid;
    logic [N_IN-1:0]    r_buf_data;
    logic [SAMP_W-1:0]  r_n_samples;
    logic [SAMP_W-1:0]  r_samp_cnt;
    logic [CNT_W-1:0]   r_cnt [N_OUT];
    logic [N_IN-1:0]    r_in_spikes;
    logic [CLS_W-1:0]   r_res_class;
    logic [CNT_W-1:0]   r_res_count;

    logic               w_load;
    logic               w_clear;
    logic               w_accum;
    logic               w_samp_step;
    logic               w_in_hs;
    logic               w_done_entry;
    logic [SAMP_W-1:0]  w_samp_inc;
    logic [CNT_W-1:0]   w_cnt_nxt [N_OUT];
    logic [CLS_W-1:0]   w_best_idx;
    logic [CNT_W-1:0]   w_best_val;

    assign w_in_hs    = i_in_valid && !r_buf_valid && !i_abort;
    assign w_samp_inc = r_samp_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_accum     = 1'b0;
        w_samp_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_go && (i_cfg_n_samples != '0)) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_WAIT_NET;
                end
            end
            S_WAIT_NET: begin
                if (i_net_ready && r_buf_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_accum = 1'b1;
                if (i_net_sample) begin
                    w_samp_step = 1'b1;
                    if (w_samp_inc == r_n_samples) begin
                        w_state_nxt = S_DONE;
                    end else if (r_buf_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (r_buf_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (i_res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort overrides every event decoded above, including accumulation.
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b0;
            w_clear     = 1'b0;
            w_accum     = 1'b0;
            w_samp_step = 1'b0;
        end
    end

    // The final sampling cycle still accumulates, so the winner is chosen
    // from the next-cycle counter values.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_accum && i_net_out_spikes[i] && (r_cnt[i] != c_cnt_max)) begin
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
        end
        w_best_idx = '0;
        w_best_val = w_cnt_nxt[0];
        for (int i = 1; i < N_OUT; i++) begin
            if (w_cnt_nxt[i] > w_best_val) begin
                w_best_val = w_cnt_nxt[i];
                w_best_idx = CLS_W'(i);
            end
        end
    end

    assign w_done_entry = (r_state == S_RUN) && (w_state_nxt == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
            r_in_spikes <= '0;
        end else begin
            if (i_abort || w_load) begin
                r_buf_valid <= 1'b0;
            end else if (w_in_hs) begin
                r_buf_valid <= 1'b1;
                r_buf_data  <= i_in_data;
            end
            if (w_load) begin
                r_in_spikes <= r_buf_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_samples <= '0;
            r_samp_cnt  <= '0;
            r_res_class <= '0;
            r_res_count <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_clear) begin
                r_n_samples <= i_cfg_n_samples;
                r_samp_cnt  <= '0;
            end else if (w_samp_step) begin
                r_samp_cnt <= w_samp_inc;
            end
            for (int i = 0; i < N_OUT; i++) begin
                r_cnt[i] <= w_clear ? '0 : w_cnt_nxt[i];
            end
            if (w_done_entry) begin
                r_res_class <= w_best_idx;
                r_res_count <= w_best_val;
            end
        end
    end

    assign o_in_ready         = !r_buf_valid;
    assign o_net_start        = (r_state == S_RUN) || (r_state == S_STALL);
    assign o_net_sample_ready = (r_state == S_RUN) && r_buf_valid;
    assign o_net_in_spikes    = r_in_spikes;
    assign o_res_valid        = (r_state == S_DONE);
    assign o_res_class        = r_res_class;
    assign o_res_count        = r_res_count;

endmodule
`default_nettype wire

// File: tb/tb_inference_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inference_ctrl
// Description : Self-checking bench for inference_ctrl (CNT_W=8 and CNT_W=4
//               instances driven in parallel against one reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inference_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic       net_ready = 1'b0, net_sample = 1'b0, res_ready = 1'b0;
    logic [7:0] cfg = 8'd0;
    logic [3:0] in_data = 4'd0;
    logic [1:0] out_spk = 2'd0;

    logic       in_ready_a, net_start_a, nsr_a, rv_a;
    logic [3:0] spk_a;
    logic [0:0] rc_a;
    logic [7:0] cnt_a;
    logic       in_ready_b, net_start_b, nsr_b, rv_b;
    logic [3:0] spk_b;
    logic [0:0] rc_b;
    logic [3:0] cnt_b;

    always #5 clk = ~clk;

    inference_ctrl #(.N_IN(4), .N_OUT(2), .SAMP_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_go(go), .i_abort(abort),
        .i_cfg_n_samples(cfg), .i_in_valid(in_valid), .o_in_ready(in_ready_a),
        .i_in_data(in_data), .o_net_start(net_start_a), .i_net_ready(net_ready),
        .i_net_sample(net_sample), .o_net_sample_ready(nsr_a),
        .o_net_in_spikes(spk_a), .i_net_out_spikes(out_spk),
        .o_res_valid(rv_a), .i_res_ready(res_ready),
        .o_res_class(rc_a), .o_res_count(cnt_a));

    inference_ctrl #(.N_IN(4), .N_OUT(2), .SAMP_W(8), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_go(go), .i_abort(abort),
        .i_cfg_n_samples(cfg), .i_in_valid(in_valid), .o_in_ready(in_ready_b),
        .i_in_data(in_data), .o_net_start(net_start_b), .i_net_ready(net_ready),
        .i_net_sample(net_sample), .o_net_sample_ready(nsr_b),
        .o_net_in_spikes(spk_b), .i_net_out_spikes(out_spk),
        .o_res_valid(rv_b), .i_res_ready(res_ready),
        .o_res_class(rc_b), .o_res_count(cnt_b));

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 waiting for network, 2 running,
    // 3 stalled, 4 result pending. Spike counts are kept unbounded.
    int         m_phase;
    bit         m_full;
    logic [3:0] m_buf, m_spk;
    int         m_n, m_done;
    int         m_cnt [2];
    int         e_cls [2];
    int         e_cnt [2];
    int         caps  [2] = '{255, 15};

    bit         use_q;
    logic [3:0] q[$];
    int         per, run_age;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_full = 0; m_buf = 0; m_spk = 0; m_n = 0; m_done = 0;
        run_age = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; e_cls[k] = 0; e_cnt[k] = 0;
        end
    endtask

    task automatic model_step();
        bit hs;
        hs = in_valid && !m_full;
        if (abort) begin
            m_phase = 0;
            m_full  = 0;
            return;
        end
        case (m_phase)
            0: if (go && cfg != 0) begin
                m_n = cfg; m_done = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_phase = 1;
            end
            1: if (net_ready && m_full) begin
                m_spk = m_buf; m_full = 0; m_phase = 2;
            end
            2: begin
                for (int i = 0; i < 2; i++) m_cnt[i] += out_spk[i];
                if (net_sample) begin
                    m_done++;
                    if (m_done == m_n) begin
                        m_phase = 4;
                        for (int k = 0; k < 2; k++) begin
                            e_cls[k] = (sat(m_cnt[1], caps[k]) > sat(m_cnt[0], caps[k])) ? 1 : 0;
                            e_cnt[k] = sat(m_cnt[e_cls[k]], caps[k]);
                        end
                    end else if (m_full) begin
                        m_spk = m_buf; m_full = 0;
                    end else begin
                        m_phase = 3;
                    end
                end
            end
            3: if (m_full) begin
                m_spk = m_buf; m_full = 0; m_phase = 2;
            end
            4: if (res_ready) m_phase = 0;
            default: m_phase = 0;
        endcase
        if (hs) begin
            m_full = 1;
            m_buf  = in_data;
        end
    endtask

    task automatic check_all();
        chk("in_ready_a",  in_ready_a,  !m_full);
        chk("in_ready_b",  in_ready_b,  !m_full);
        chk("net_start_a", net_start_a, (m_phase == 2 || m_phase == 3));
        chk("net_start_b", net_start_b, (m_phase == 2 || m_phase == 3));
        chk("nsr_a",       nsr_a,       (m_phase == 2 && m_full));
        chk("nsr_b",       nsr_b,       (m_phase == 2 && m_full));
        chk("spikes_a",    spk_a,       m_spk);
        chk("spikes_b",    spk_b,       m_spk);
        chk("res_valid_a", rv_a,        (m_phase == 4));
        chk("res_valid_b", rv_b,        (m_phase == 4));
        chk("res_class_a", rc_a,        e_cls[0]);
        chk("res_class_b", rc_b,        e_cls[1]);
        chk("res_count_a", cnt_a,       e_cnt[0]);
        chk("res_count_b", cnt_b,       e_cnt[1]);
    endtask

    // Drives the upstream queue and the network's sample requests, advances
    // the model and the DUTs one clock, then compares at the falling edge.
    task automatic step();
        int  oldp;
        bit  hs;
        if (use_q) begin
            in_valid = (q.size() > 0);
            in_data  = (q.size() > 0) ? q[0] : 4'd0;
        end
        if (per > 0) net_sample = (m_phase == 2) && (run_age == per - 1);
        else         net_sample = ((m_phase == 2) && ($urandom % 6 == 0)) || ($urandom % 20 == 0);
        oldp = m_phase;
        hs   = in_valid && !m_full;
        model_step();
        if (use_q && hs) void'(q.pop_front());
        if (oldp == 2 && !abort && !net_sample) run_age++;
        else                                     run_age = 0;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic start_run(input logic [7:0] n);
        cfg = n; go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic finish_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        use_q = 1; per = 10;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  in_ready_a, 1);
        chk("rst_net_start", net_start_a, 0);
        chk("rst_res_valid", rv_a, 0);
        chk("rst_res_count", cnt_a, 0);
        check_all();
        rst_n = 1'b1;

        // Basic run: three samples of ten cycles each, output 0 always firing.
        net_ready = 1'b1; out_spk = 2'b01;
        q = '{4'hF, 4'hE, 4'hD};
        repeat (2) step();
        start_run(8'd3);
        for (int k = 0; k < 100 && m_phase != 4; k++) step();
        chk("basic_valid", rv_a, 1);
        chk("basic_class", rc_a, 0);
        chk("basic_count", cnt_a, 30);
        chk("basic_count_sat4", cnt_b, 15);
        chk("basic_last_vec", spk_a, 4'hD);
        repeat (5) step();
        chk("hold_count", cnt_a, 30);
        finish_result();
        chk("basic_release", rv_a, 0);

        // Stall: second vector withheld for seven cycles.
        q = '{4'hA};
        start_run(8'd2);
        for (int k = 0; k < 60 && m_phase != 3; k++) step();
        chk("stall_net_start", net_start_a, 1);
        repeat (7) step();
        chk("stall_nsr", nsr_a, 0);
        q.push_back(4'hB);
        for (int k = 0; k < 60 && m_phase != 4; k++) step();
        chk("stall_count", cnt_a, 20);
        chk("stall_vec", spk_a, 4'hB);
        finish_result();

        // Tie and saturation over 40 cycles.
        per = 40; out_spk = 2'b11; q = '{4'h1};
        start_run(8'd1);
        for (int k = 0; k < 80 && m_phase != 4; k++) step();
        chk("tie_class_4", rc_b, 0);
        chk("tie_count_4", cnt_b, 15);
        chk("tie_count_8", cnt_a, 40);
        finish_result();

        // Abort in the middle of a run, then a clean run from cleared counters.
        per = 10; out_spk = 2'b10; q = '{4'h2, 4'h3};
        start_run(8'd3);
        for (int k = 0; k < 20 && m_phase != 2; k++) step();
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_net_start", net_start_a, 0);
        chk("abort_in_ready", in_ready_a, 1);
        q = '{4'h5};
        start_run(8'd1);
        for (int k = 0; k < 40 && m_phase != 4; k++) step();
        chk("post_abort_class", rc_a, 1);
        chk("post_abort_count", cnt_a, 10);
        finish_result();

        // go with zero samples is ignored; the buffered vector stays put.
        q = '{4'h6, 4'h7};
        repeat (2) step();
        start_run(8'd0);
        repeat (3) step();
        chk("zero_n_in_ready", in_ready_a, 0);
        chk("zero_n_idle", net_start_a, 0);

        // Asynchronous reset in the middle of a run.
        start_run(8'd2);
        for (int k = 0; k < 20 && m_phase != 2; k++) step();
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_net_start", net_start_a, 0);
        chk("arst_in_ready", in_ready_a, 1);
        chk("arst_spikes", spk_a, 0);
        chk("arst_res_count", cnt_a, 0);
        chk("arst_nsr", nsr_a, 0);
        model_reset();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        use_q = 0; per = 0;
        for (int c = 0; c < 4000; c++) begin
            in_valid  = $urandom % 2;
            in_data   = 4'($urandom);
            net_ready = ($urandom % 4) != 0;
            out_spk   = 2'($urandom);
            res_ready = $urandom % 2;
            abort     = ($urandom % 150) == 0;
            go        = ($urandom % 4) == 0;
            cfg       = 8'($urandom % 6);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inference_ctrl.md
INFERENCE_CTRL -- requirements
Module: inference_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N_IN, 4, input spike vector width; N_OUT, 2, output spike vector width; SAMP_W, 8, sample-count width; CNT_W, 8, per-output spike counter width.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low. Ports are listed as name, direction, width, meaning.
REQ-003 clk, in, 1, single clock, all state updates on rising edge.
REQ-004 rst_n, in, 1, asynchronous active-low reset.
REQ-005 go, in, 1, one-cycle request to start an inference; sampled only in IDLE.
REQ-006 abort, in, 1, forces return to IDLE from any state.
REQ-007 cfg_n_samples, in, SAMP_W, number of samples per inference; latched on accepted go.
REQ-008 in_valid / in_ready / in_data, in / out / out-in, 1 / 1 / N_IN, upstream spike-vector valid-ready handshake.
REQ-009 net_start, out, 1, held high while the network runs.
REQ-010 net_ready, in, 1, network idle and able to start.
REQ-011 net_sample, in, 1, one-cycle pulse from network requesting the next input vector.
REQ-012 net_sample_ready, out, 1, next input vector is available.
REQ-013 net_in_spikes, out, N_IN, input vector presented to the network, held between loads.
REQ-014 net_out_spikes, in, N_OUT, output spikes from the network, sampled every cycle.
REQ-015 res_valid / res_ready, out / in, 1 / 1, result handshake.
REQ-016 res_class, out, ceil(log2(N_OUT)) (min 1), index of the winning output.
REQ-017 res_count, out, CNT_W, spike count of the winning output.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_NET, RUN, STALL, DONE.
REQ-019 Input buffer: single entry; in_ready=!buf_valid; handshake in_valid&&in_ready sets buf_valid and captures in_data; no same-cycle pass-through.
REQ-020 IDLE: go=1 with cfg_n_samples!=0 latches n_samples, clears samp_cnt and all spike counters, and moves to WAIT_NET; go with cfg_n_samples==0 is ignored.
REQ-021 WAIT_NET: when net_ready=1 and buf_valid=1, load net_in_spikes from the buffer, clear buf_valid, and move to RUN with net_start=1 from the next cycle.
REQ-022 net_sample_ready SHALL equal buf_valid in RUN and 0 in all other states.
REQ-023 RUN: each cycle, for every i with net_out_spikes[i]=1, counter i increments by 1, saturating at 2^CNT_W-1.
REQ-024 RUN with net_sample=1: samp_cnt increments; if the new samp_cnt==n_samples, go to DONE and drop net_start.
REQ-025 In the same net_sample case, if samp_cnt has not reached n_samples and buf_valid=1, load net_in_spikes from the buffer, clear buf_valid, and stay in RUN.
REQ-026 In the same net_sample case, if samp_cnt has not reached n_samples and buf_valid=0, go to STALL.
REQ-027 The spike accumulation of the cycle in which net_sample=1 SHALL still count.
REQ-028 STALL: counters are frozen and net_start stays 1; when buf_valid=1, load the buffer, clear buf_valid, and return to RUN.
REQ-029 DONE: res_valid=1; res_class is the index of the maximum counter (lowest index on a tie); res_count is that counter's value.
REQ-030 res_class and res_count SHALL be registered on DONE entry and held stable while res_valid=1.
REQ-031 DONE with res_ready=1 SHALL return to IDLE next cycle, deasserting res_valid; the buffer contents are kept.
REQ-032 abort=1 SHALL take priority over every other event: the next state is IDLE, net_start=0, res_valid=0, and buf_valid=0.
REQ-033 An input handshake in a cycle with abort=1 SHALL be discarded.
REQ-034 Latency: net_start SHALL rise exactly 1 cycle after the WAIT_NET exit condition holds; res_valid SHALL rise 1 cycle after the final net_sample.

Reset
REQ-035 On rst_n=0, asynchronously: state=IDLE; net_start=0; net_sample_ready=0; net_in_spikes=0; res_valid=0; res_class=0; res_count=0; buf_valid=0 (so in_ready=1); all counters and samp_cnt=0.
REQ-036 Reset deassertion SHALL take effect on the first rising clk edge with rst_n=1.

Verification
REQ-037 Basic run: reset; push 0xF, 0xE, 0xD; set cfg_n_samples=3; pulse go; network model gives net_ready=1, net_sample every 10 cycles, and out_spikes=2'b01 every cycle -> res_valid=1, res_class=0, res_count=30.
REQ-038 Stall: cfg_n_samples=2; second vector withheld for 7 cycles after the first net_sample -> STALL, net_sample_ready=0, counters frozen; vector arrives -> RUN, in_spikes updated next cycle.
REQ-039 Tie and saturation: CNT_W=4, out_spikes=2'b11 for 40 cycles -> both counters 15, res_class=0, res_count=15.
REQ-040 Abort: abort=1 in the middle of RUN -> next cycle state IDLE, net_start=0, in_ready=1; a subsequent go runs from cleared counters.
REQ-041 Boundaries: go with cfg_n_samples=0 -> stays IDLE. res_ready held 0 for 5 cycles -> result stable. Reset asserted mid-RUN -> all outputs immediately reach the REQ-035 values.
